// File: rtl/reg_wb_buffer.sv
// Purpose : in-order write-back queue feeding the single register-file write port, with read-port forwarding.
// Latency : an entry accepted at edge N drives Wn/Wd and the lookup from cycle N+1; no same-cycle bypass.
// Backpressure: InReady = !Full; DrainEn never frees a slot in the same cycle; InWn==0 is accepted and discarded.
//
// Ports:
//   Clock, Resetn            rising-edge clock, asynchronous active-low reset
//   InValid/InReady/InWn/InWd producer handshake carrying destination register and result
//   DrainEn                  write port granted this cycle; Write/Wn/Wd retire the head entry
//   Rn1/Rn2 -> Hit1/Fwd1, Hit2/Fwd2  youngest pending value for each read port
//   Count/Empty/Full         occupancy
module reg_wb_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          InValid,
   output logic          InReady,
   input  logic [4:0]    InWn,
   input  logic [31:0]   InWd,
   input  logic          DrainEn,
   output logic          Write,
   output logic [4:0]    Wn,
   output logic [31:0]   Wd,
   input  logic [4:0]    Rn1,
   input  logic [4:0]    Rn2,
   output logic          Hit1,
   output logic          Hit2,
   output logic [31:0]   Fwd1,
   output logic [31:0]   Fwd2,
   output logic [AW:0]   Count,
   output logic          Empty,
   output logic          Full
);

   logic [4:0]       ent_wn [DEPTH];
   logic [31:0]      ent_wd [DEPTH];
   logic [DEPTH-1:0] ent_vld;
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;
   logic [AW:0]      count;
   logic             push;
   logic             pop;
   logic [AW-1:0]    idx;

   assign Empty   = (count == '0);
   assign Full    = (count == (AW+1)'(DEPTH));
   assign InReady = !Full;
   assign Count   = count;

   // $0 is never written: the handshake still completes but nothing is queued.
   assign push = InValid && InReady && (InWn != 5'd0);
   assign pop  = DrainEn && !Empty;

   assign Write = pop;
   assign Wn    = pop ? ent_wn[head] : 5'd0;
   assign Wd    = pop ? ent_wd[head] : 32'd0;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         ent_vld <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_wn[i] <= '0;
            ent_wd[i] <= '0;
         end
      end else begin
         // push needs !Full and pop needs !Empty, so head and tail never
         // address the same slot when both fire.
         if (pop) begin
            ent_vld[head] <= 1'b0;
            head          <= head + AW'(1);
         end
         if (push) begin
            ent_wn[tail]  <= InWn;
            ent_wd[tail]  <= InWd;
            ent_vld[tail] <= 1'b1;
            tail          <= tail + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Walk occupied entries oldest to youngest; a later match overrides an
   // earlier one, so the youngest match wins. The head entry stays visible
   // while it drains, matching the register file updating at the same edge.
   always_comb begin
      Hit1 = 1'b0;
      Fwd1 = 32'd0;
      Hit2 = 1'b0;
      Fwd2 = 32'd0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if (((AW+1)'(i) < count) && ent_vld[idx]) begin
            if ((Rn1 != 5'd0) && (ent_wn[idx] == Rn1)) begin
               Hit1 = 1'b1;
               Fwd1 = ent_wd[idx];
            end
            if ((Rn2 != 5'd0) && (ent_wn[idx] == Rn2)) begin
               Hit2 = 1'b1;
               Fwd2 = ent_wd[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_wb_buffer.sv
module tb_reg_wb_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          Clock = 1'b0;
   logic          Resetn = 1'b0;
   logic          InValid = 1'b0;
   logic          InReady;
   logic [4:0]    InWn = '0;
   logic [31:0]   InWd = '0;
   logic          DrainEn = 1'b0;
   logic          Write;
   logic [4:0]    Wn;
   logic [31:0]   Wd;
   logic [4:0]    Rn1 = '0;
   logic [4:0]    Rn2 = '0;
   logic          Hit1, Hit2;
   logic [31:0]   Fwd1, Fwd2;
   logic [AW:0]   Count;
   logic          Empty, Full;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   typedef struct {
      logic [4:0]  wn;
      logic [31:0] wd;
   } ent_t;
   ent_t mq[$];

   reg_wb_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .Clock(Clock), .Resetn(Resetn),
      .InValid(InValid), .InReady(InReady), .InWn(InWn), .InWd(InWd),
      .DrainEn(DrainEn), .Write(Write), .Wn(Wn), .Wd(Wd),
      .Rn1(Rn1), .Rn2(Rn2), .Hit1(Hit1), .Hit2(Hit2), .Fwd1(Fwd1), .Fwd2(Fwd2),
      .Count(Count), .Empty(Empty), .Full(Full)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Youngest pending entry for register rn, as {hit, value}.
   function automatic logic [32:0] mlook(input logic [4:0] rn);
      if (rn == 5'd0) return 33'd0;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].wn == rn) return {1'b1, mq[i].wd};
      return 33'd0;
   endfunction

   // Reference queue: the buffer is just an ordered list of pending writes.
   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         mq.delete();
      end else begin
         bit do_pop, do_push;
         do_pop  = DrainEn && (mq.size() > 0);
         do_push = InValid && (mq.size() < DEPTH) && (InWn != 5'd0);
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back('{InWn, InWd});
      end
   end

   // Per-cycle comparison against the reference, after inputs settle.
   always @(negedge Clock) begin
      #2;
      if (cmp_en) begin
         int n;
         logic [32:0] l1, l2;
         bit ew;
         n  = mq.size();
         ew = DrainEn && (n > 0);
         l1 = mlook(Rn1);
         l2 = mlook(Rn2);
         check("m_count",   32'(Count),   32'(n));
         check("m_empty",   32'(Empty),   32'(n == 0));
         check("m_full",    32'(Full),    32'(n == DEPTH));
         check("m_inready", 32'(InReady), 32'(n < DEPTH));
         check("m_write",   32'(Write),   32'(ew));
         check("m_wn",      32'(Wn),      ew ? 32'(mq[0].wn) : 32'd0);
         check("m_wd",      Wd,           ew ? mq[0].wd : 32'd0);
         check("m_hit1",    32'(Hit1),    32'(l1[32]));
         check("m_fwd1",    Fwd1,         l1[31:0]);
         check("m_hit2",    32'(Hit2),    32'(l2[32]));
         check("m_fwd2",    Fwd2,         l2[31:0]);
      end
   end

   // Inputs change on the falling edge; literal checks follow 3 time units later.
   task automatic drive(input logic iv, input logic [4:0] wn, input logic [31:0] wd, input logic de);
      @(negedge Clock);
      InValid = iv;
      InWn    = wn;
      InWd    = wd;
      DrainEn = de;
      #3;
   endtask

   initial begin
      cmp_en = 1'b1;
      repeat (3) @(negedge Clock);
      Resetn = 1'b1;

      // Reset then idle
      Rn1 = 5'd5;
      drive(0, 0, 0, 0);
      check("rst_empty",   32'(Empty),   1);
      check("rst_inready", 32'(InReady), 1);
      check("rst_write",   32'(Write),   0);
      check("rst_count",   32'(Count),   0);
      check("rst_hit1",    32'(Hit1),    0);

      // Fill then drain
      drive(1, 5, 32'h11, 0);
      drive(1, 6, 32'h22, 0);
      drive(1, 7, 32'h33, 0);
      drive(1, 8, 32'h44, 0);
      drive(1, 9, 32'h55, 0);
      check("fill_full",    32'(Full),    1);
      check("fill_inready", 32'(InReady), 0);
      drive(0, 0, 0, 1);
      check("fill_count4", 32'(Count), 4);
      check("drain0_wn", 32'(Wn), 5); check("drain0_wd", Wd, 32'h11); check("drain0_w", 32'(Write), 1);
      drive(0, 0, 0, 1);
      check("drain1_wn", 32'(Wn), 6); check("drain1_wd", Wd, 32'h22);
      drive(0, 0, 0, 1);
      check("drain2_wn", 32'(Wn), 7); check("drain2_wd", Wd, 32'h33);
      drive(0, 0, 0, 1);
      check("drain3_wn", 32'(Wn), 8); check("drain3_wd", Wd, 32'h44);
      drive(0, 0, 0, 0);
      check("drain_empty", 32'(Empty), 1);

      // Forwarding priority
      Rn1 = 5'd9;
      Rn2 = 5'd0;
      drive(1, 9, 32'hA, 0);
      drive(1, 9, 32'hB, 0);
      drive(0, 0, 0, 0);
      check("fwd_hit1", 32'(Hit1), 1);
      check("fwd_fwd1", Fwd1, 32'hB);
      check("fwd_hit2", 32'(Hit2), 0);
      check("fwd_fwd2", Fwd2, 32'h0);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      check("fwd_after1", Fwd1, 32'hB);
      drive(0, 0, 0, 0);
      check("fwd_after2_hit", 32'(Hit1), 0);

      // $0 discard
      drive(1, 0, 32'hDEAD, 0);
      check("zero_inready", 32'(InReady), 1);
      drive(0, 0, 0, 1);
      check("zero_count", 32'(Count), 0);
      check("zero_write", 32'(Write), 0);

      // Streaming with wrap
      Rn1 = 5'd3;
      for (int k = 1; k <= 10; k++) begin
         drive(1, 3, 32'(k), 1);
         check("stream_count_le1", 32'(Count <= 1), 1);
         check("stream_write", 32'(Write), (k == 1) ? 32'd0 : 32'd1);
         if (k > 1) check("stream_wd", Wd, 32'(k - 1));
      end
      drive(0, 0, 0, 1);
      check("stream_last_w",  32'(Write), 1);
      check("stream_last_wd", Wd, 32'd10);
      drive(0, 0, 0, 0);
      check("stream_empty", 32'(Empty), 1);

      // Reset mid-operation
      drive(1, 1, 32'd100, 0);
      drive(1, 2, 32'd200, 0);
      drive(1, 4, 32'd300, 0);
      drive(0, 0, 0, 1);
      check("mid_pre_write", 32'(Write), 1);
      check("mid_pre_wn",    32'(Wn), 1);
      #1 Resetn = 1'b0;
      #1;
      check("mid_rst_write", 32'(Write), 0);
      check("mid_rst_count", 32'(Count), 0);
      @(negedge Clock);
      Resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1);
         check("mid_post_write", 32'(Write), 0);
      end

      // Randomized traffic against the reference queue
      for (int k = 0; k < 3000; k++) begin
         @(negedge Clock);
         InValid = 1'($urandom_range(0, 1));
         InWn    = 5'($urandom_range(0, 7));
         InWd    = $urandom;
         DrainEn = ($urandom_range(0, 99) < 45);
         Rn1     = 5'($urandom_range(0, 7));
         Rn2     = 5'($urandom_range(0, 7));
      end
      drive(0, 0, 0, 0);
      @(negedge Clock);
      #4;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
